// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, FSM encoding and midscale helper for the sine PWM sequencer
package pwm_pkg;

  localparam int  R_DEF     = 6;
  localparam int  N_DEF     = 2000;
  localparam int  STEPS_DEF = 36;
  localparam real PI        = 3.14159265358979;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int mid(input int r);
    return 2 ** (r - 1);
  endfunction

endpackage

// File: rtl/seno_rom.sv
// rtl/seno_rom.sv - combinational one-cycle sine table, R-bit entries, midscale beyond STEPS
module seno_rom
  import pwm_pkg::*;
#(
  parameter int R     = R_DEF,
  parameter int STEPS = STEPS_DEF
) (
  input  logic [5:0]   addr,
  output logic [R-1:0] data
);

  // All 64 address slots are filled so out-of-range addresses fall out as midscale.
  function automatic logic [64*R-1:0] build_table();
    logic [64*R-1:0] t;
    real             v;
    int              q;
    t = '0;
    for (int k = 0; k < 64; k++) begin
      if (k < STEPS) begin
        v = (2.0 ** R) * (0.5 + 0.5 * $sin(2.0 * PI * k / STEPS));
        q = $rtoi(v + 0.5);
        if (q < 0) q = 0;
        if (q > 2 ** R - 1) q = 2 ** R - 1;
      end else begin
        q = mid(R);
      end
      t[k*R +: R] = R'(q);
    end
    return t;
  endfunction

  localparam logic [64*R-1:0] TABLE = build_table();

  assign data = TABLE[addr*R +: R];

endmodule

// File: rtl/pwm_seno_secuenciador.sv
// rtl/pwm_seno_secuenciador.sv - steps a sine duty table every N PWM periods with a valid strobe
module pwm_seno_secuenciador
  import pwm_pkg::*;
#(
  parameter int R     = R_DEF,
  parameter int N     = N_DEF,
  parameter int STEPS = STEPS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         period_tick,
  input  logic [5:0]   stride,
  output logic [R-1:0] duty,
  output logic         duty_valid,
  output logic [5:0]   idx,
  output logic         cycle_done
);

  localparam int             NW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [NW-1:0]  N_LAST = NW'(N - 1);
  localparam logic [R-1:0]   MID    = R'(mid(R));
  localparam logic [6:0]     STEPS7 = 7'(STEPS);

  state_t        state;
  logic [NW-1:0] n;
  logic [6:0]    s_eff;
  logic [6:0]    sum;
  logic          wrap;
  logic [5:0]    next_idx;
  logic [5:0]    rom_addr;
  logic [R-1:0]  rom_data;

  always_comb begin
    s_eff = {1'b0, stride};
    if (stride == 6'd0)
      s_eff = 7'd1;
    else if ({1'b0, stride} >= STEPS7)
      s_eff = STEPS7 - 7'd1;
    sum      = {1'b0, idx} + s_eff;
    wrap     = (sum >= STEPS7);
    next_idx = wrap ? 6'(sum - STEPS7) : sum[5:0];
    // START loads entry 0; RUN looks up the index the next step will land on.
    rom_addr = (state == RUN) ? next_idx : 6'd0;
  end

  seno_rom #(
    .R     (R),
    .STEPS (STEPS)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      n          <= '0;
      duty       <= MID;
      duty_valid <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) state <= START;
        end
        START, RUN: begin
          // Dropping en parks the output at midscale and beats any coincident tick.
          if (!en) begin
            state      <= IDLE;
            duty       <= MID;
            duty_valid <= 1'b1;
            n          <= '0;
          end else if (state == START) begin
            state      <= RUN;
            idx        <= '0;
            n          <= '0;
            duty       <= rom_data;
            duty_valid <= 1'b1;
          end else if (period_tick) begin
            if (n == N_LAST) begin
              n          <= '0;
              idx        <= next_idx;
              duty       <= rom_data;
              duty_valid <= 1'b1;
              cycle_done <= wrap;
            end else begin
              n <= n + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_seno_secuenciador.md
Name: pwm_seno_secuenciador

Overview:
Upstream duty-cycle sequencer for the R-bit PWM stage. It holds a quantized one-cycle sine table of STEPS entries and advances through it every N PWM periods. Period boundaries are counted from a one-cycle tick issued by the PWM stage when its counter wraps. Each new R-bit duty word goes out with a one-cycle valid strobe; the PWM stage latches duty on that strobe.

Parameters:
R, 6, PWM resolution in bits; width of duty.
N, 2000, PWM periods held per table step (N >= 1).
STEPS, 36, table entries per sine cycle (2..63).

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
en  in  1  run enable; level
period_tick  in  1  one-cycle pulse from PWM stage at counter wrap (Q_reg == 2**R-1)
stride  in  6  table index increment per step; sampled at each step
duty  out  R  current duty word
duty_valid  out  1  one-cycle strobe; duty is new this cycle
idx  out  6  current table index
cycle_done  out  1  one-cycle pulse when idx wraps past STEPS-1

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, idx=0, period count n=0.
  - duty=2**(R-1) (midscale; 32 for R=6).
  - duty_valid=0, cycle_done=0.
- Table: entry k = round(2**R * (0.5 + 0.5*sin(2*pi*k/STEPS))), saturated to [0, 2**R-1].
  - For R=6, STEPS=36: k=0 -> 32, k=3 -> 48, k=9 -> 63, k=18 -> 32, k=27 -> 0.
- FSM states: IDLE, START, RUN.
  - IDLE: outputs hold. en=1 -> START.
  - START (one cycle): idx<=0, n<=0, duty<=table[0], duty_valid=1 on the following cycle; -> RUN.
  - RUN: on each period_tick: if n==N-1 then n<=0 and step, else n<=n+1. period_tick with en=1 in any other state is ignored.
- Step, issued on the edge that sees the Nth tick:
  - idx <= (idx + s) mod STEPS.
  - duty <= table[new idx].
  - duty_valid=1 in the cycle where the new duty first appears, i.e. one clock after the tick.
- Effective stride s:
  - stride==0 -> s=1.
  - stride>=STEPS -> s=STEPS-1.
  - Otherwise s=stride.
- Index arithmetic: 7-bit sum, subtract STEPS once if sum>=STEPS. cycle_done=1 in the same cycle as that step's duty_valid whenever the subtraction occurred.
- en falls (any state except IDLE):
  - Next cycle: state=IDLE, duty<=2**(R-1), duty_valid=1, n<=0.
  - idx holds its value.
  - en=0 takes priority over a coincident period_tick; no step occurs.
- en re-asserted from IDLE always restarts at idx=0.
- rst mid-run: all state returns to reset values next cycle; no duty_valid is emitted.
- duty and idx are registered and change only together with duty_valid.
- N=1 steps on every period_tick.
- n width: clog2(N) bits, minimum 1.

Decomposition:
- Shared package pwm_pkg:
  - Constants R_DEF=6, N_DEF=2000, STEPS_DEF=36.
  - FSM state encoding IDLE/START/RUN.
  - Midscale function mid(R)=2**(R-1).
- Sub-module seno_rom: parameters R and STEPS; input addr[5:0], output data[R-1:0].
  - Combinational table built by an elaborated function; no hand-entered literals.
  - addr>=STEPS returns midscale.
- Sequencer top: FSM, period counter, index adder, output registers.

Test Plan:
- Reset: hold rst 3 cycles, release with en=0 -> duty=32, idx=0, duty_valid=0, cycle_done=0 for 10 cycles; period_tick pulses ignored.
- Start/step (N=3, stride=1): assert en -> one duty_valid with duty=32, idx=0. After 3 period_ticks -> duty_valid one clock after the 3rd tick, idx=1, duty=table[1]; no strobe after ticks 1 and 2.
- Full cycle and wrap (N=1, stride=1): 36 ticks -> duty walks 32…63 (idx 9)…0 (idx 27)…back to 32. cycle_done pulses exactly once, coincident with idx=0.
- Stride limits (N=1): stride=9 -> idx 0,9,18,27,0 with cycle_done on the 4th step. stride=0 behaves as 1. stride=40 behaves as 35 -> idx 0,35,34.
- Disable priority: en falls in the same cycle as the Nth tick -> next cycle duty=32, duty_valid=1, idx unchanged, state IDLE. Re-enable -> restart at idx=0.
- Reset mid-run: rst=1 while idx=5 and n=1 -> next cycle idx=0, duty=32, no duty_valid, state IDLE.
